// File: rtl/reg_file_mp.sv
// reg_file_mp: 2R/2W register file with write bypass, busy scoreboard and post-reset clear engine.
module reg_file_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ready,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] read_data2,
    output logic            busy1,
    output logic            busy2,
    input  logic            we0,
    input  logic            we1,
    input  logic [AW-1:0]   rd0,
    input  logic [AW-1:0]   rd1,
    input  logic [XLEN-1:0] wd0,
    input  logic [XLEN-1:0] wd1,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_rd
);
    typedef enum logic {CLEAR, RUN} state_t;
    state_t state, state_nx;
    logic [AW-1:0] clr_idx;
    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic wen0, wen1, rsv_ok;
    logic zero1, zero2, byp0_1, byp1_1, byp0_2, byp1_2;
    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (state == CLEAR && clr_idx == AW'(NREGS - 1)) state_nx = RUN;
    end
    assign ready = (state == RUN);
    // Address 0 is a sink for writes and reserves when it is hardwired.
    assign wen0   = ready && we0 && !(ZERO_REG != 0 && rd0 == '0);
    assign wen1   = ready && we1 && !(ZERO_REG != 0 && rd1 == '0);
    assign rsv_ok = ready && rsv_en && !(ZERO_REG != 0 && rsv_rd == '0);
    always_ff @(posedge clk) begin
        if (rst) clr_idx <= '0;
        else if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!ready) regs[clr_idx] <= '0;
            else begin
                if (wen0) regs[rd0] <= wd0;
                if (wen1) regs[rd1] <= wd1;
            end
        end
    end
    // Reserve is applied last so it overrides a same-cycle writeback clear.
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else begin
            if (wen0)   busy[rd0]    <= 1'b0;
            if (wen1)   busy[rd1]    <= 1'b0;
            if (rsv_ok) busy[rsv_rd] <= 1'b1;
        end
    end
    assign zero1  = ZERO_REG != 0 && rs1 == '0;
    assign zero2  = ZERO_REG != 0 && rs2 == '0;
    assign byp1_1 = BYPASS != 0 && wen1 && rd1 == rs1;
    assign byp0_1 = BYPASS != 0 && wen0 && rd0 == rs1;
    assign byp1_2 = BYPASS != 0 && wen1 && rd1 == rs2;
    assign byp0_2 = BYPASS != 0 && wen0 && rd0 == rs2;
    assign read_data1 = (!ready || zero1) ? '0 : byp1_1 ? wd1 : byp0_1 ? wd0 : regs[rs1];
    assign read_data2 = (!ready || zero2) ? '0 : byp1_2 ? wd1 : byp0_2 ? wd0 : regs[rs2];
    assign busy1 = ready && busy[rs1];
    assign busy2 = ready && busy[rs2];
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed checks of reg_file_mp with and without write bypass.
module tb_reg_file_mp;
    logic clk = 0, rst = 1;
    logic [4:0] rs1 = 0, rs2 = 0, rd0 = 0, rd1 = 0, rsv_rd = 0;
    logic we0 = 0, we1 = 0, rsv_en = 0;
    logic [31:0] wd0 = 0, wd1 = 0;
    logic ready, busy1, busy2, nb_ready, nb_busy1, nb_busy2;
    logic [31:0] read_data1, read_data2, nb_read_data1, nb_read_data2;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .ready(ready), .rs1(rs1), .rs2(rs2),
        .read_data1(read_data1), .read_data2(read_data2), .busy1(busy1), .busy2(busy2),
        .we0(we0), .we1(we1), .rd0(rd0), .rd1(rd1), .wd0(wd0), .wd1(wd1),
        .rsv_en(rsv_en), .rsv_rd(rsv_rd));

    reg_file_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .ready(nb_ready), .rs1(rs1), .rs2(rs2),
        .read_data1(nb_read_data1), .read_data2(nb_read_data2), .busy1(nb_busy1), .busy2(nb_busy2),
        .we0(we0), .we1(we1), .rd0(rd0), .rd1(rd1), .wd0(wd0), .wd1(wd1),
        .rsv_en(rsv_en), .rsv_rd(rsv_rd));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; rsv_en = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        rst = 0;
        #1;
        checks++;
        if (ready !== 1'b0 || nb_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b/%b want=0", ready, nb_ready);
        end
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 31 || k == 32) begin
                checks++;
                if (ready !== (k == 32) || nb_ready !== (k == 32)) begin
                    failures++;
                    $display("FAIL reset_ready_edge%0d got=%b/%b want=%b", k, ready, nb_ready, k == 32);
                end
            end
        end
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < 16; i++) begin
            we0 = 1; rd0 = 5'(i); wd0 = 32'hA500_0000 | i;
            we1 = 1; rd1 = 5'(i + 16); wd1 = 32'hA500_0000 | (i + 16);
            tick();
        end
        idle();
        for (int i = 1; i < 32; i++) begin
            rs1 = 5'(i);
            #1;
            checks++;
            if (read_data1 !== (32'hA500_0000 | i) || nb_read_data1 !== (32'hA500_0000 | i)) begin
                failures++;
                $display("FAIL fill_r%0d got=%h/%h want=%h", i, read_data1, nb_read_data1, 32'hA500_0000 | i);
            end
        end
    endtask

    task automatic test_clear();
        test_reset();
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(31 - i);
            #1;
            checks++;
            if (read_data1 !== 0 || nb_read_data2 !== 0) begin
                failures++;
                $display("FAIL clear_r%0d got=%h/%h want=0", i, read_data1, nb_read_data2);
            end
        end
    endtask

    task automatic test_collision();
        we0 = 1; we1 = 1; rd0 = 5; rd1 = 5; wd0 = 32'h11; wd1 = 32'h22;
        tick();
        idle();
        rs1 = 5;
        #1;
        checks++;
        if (read_data1 !== 32'h22 || nb_read_data1 !== 32'h22) begin
            failures++;
            $display("FAIL collision got=%h/%h want=00000022", read_data1, nb_read_data1);
        end
    endtask

    task automatic test_bypass();
        we1 = 1; rd1 = 7; wd1 = 32'h55;
        tick();
        idle();
        we0 = 1; rd0 = 7; wd0 = 32'hDEADBEEF; rs2 = 7;
        #1;
        checks++;
        if (read_data2 !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL bypass_on got=%h want=deadbeef", read_data2);
        end
        checks++;
        if (nb_read_data2 !== 32'h55) begin
            failures++;
            $display("FAIL bypass_off_old got=%h want=00000055", nb_read_data2);
        end
        tick();
        idle();
        #1;
        checks++;
        if (nb_read_data2 !== 32'hDEADBEEF || read_data2 !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL bypass_after got=%h/%h want=deadbeef", read_data2, nb_read_data2);
        end
    endtask

    task automatic test_zero();
        we0 = 1; rd0 = 0; wd0 = 32'h1234; we1 = 1; rd1 = 0; wd1 = 32'h5678;
        rsv_en = 1; rsv_rd = 0; rs1 = 0;
        #1;
        checks++;
        if (read_data1 !== 0 || nb_read_data1 !== 0) begin
            failures++;
            $display("FAIL zero_same got=%h/%h want=0", read_data1, nb_read_data1);
        end
        tick();
        idle();
        #1;
        checks++;
        if (read_data1 !== 0 || nb_read_data1 !== 0 || busy1 !== 0 || nb_busy1 !== 0) begin
            failures++;
            $display("FAIL zero_after data=%h/%h busy=%b/%b want=0", read_data1, nb_read_data1, busy1, nb_busy1);
        end
    endtask

    task automatic test_scoreboard();
        rs1 = 9; rs2 = 9;
        rsv_en = 1; rsv_rd = 9;
        #1;
        checks++;
        if (busy1 !== 0) begin
            failures++;
            $display("FAIL sb_before got=%b want=0", busy1);
        end
        tick();
        idle();
        #1;
        checks++;
        if (busy1 !== 1 || busy2 !== 1 || nb_busy1 !== 1) begin
            failures++;
            $display("FAIL sb_reserved got=%b%b%b want=111", busy1, busy2, nb_busy1);
        end
        we1 = 1; rd1 = 9; wd1 = 32'h99; rsv_en = 1; rsv_rd = 9;
        tick();
        idle();
        #1;
        checks++;
        if (busy1 !== 1) begin
            failures++;
            $display("FAIL sb_reserve_wins got=%b want=1", busy1);
        end
        we0 = 1; rd0 = 9; wd0 = 32'h77;
        #1;
        checks++;
        if (busy1 !== 1) begin
            failures++;
            $display("FAIL sb_no_forward got=%b want=1", busy1);
        end
        tick();
        idle();
        #1;
        checks++;
        if (busy1 !== 0 || busy2 !== 0 || nb_busy2 !== 0 || read_data1 !== 32'h77) begin
            failures++;
            $display("FAIL sb_cleared busy=%b%b%b data=%h want=000/00000077", busy1, busy2, nb_busy2, read_data1);
        end
        rsv_en = 1; rsv_rd = 12;
        tick();
        idle();
        rs1 = 12;
        #1;
        checks++;
        if (busy1 !== 1) begin
            failures++;
            $display("FAIL sb_pending got=%b want=1", busy1);
        end
    endtask

    task automatic test_mid_clear();
        rst = 1;
        tick();
        rst = 0;
        for (int k = 0; k < 10; k++) tick();
        rst = 1;
        tick();
        rst = 0;
        we0 = 1; rd0 = 3; wd0 = 32'hABC; we1 = 1; rd1 = 12; wd1 = 32'hDEF;
        rsv_en = 1; rsv_rd = 3; rs1 = 3; rs2 = 12;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 15) begin
                checks++;
                if (read_data1 !== 0 || busy2 !== 0) begin
                    failures++;
                    $display("FAIL midclear_outputs data=%h busy=%b want=0", read_data1, busy2);
                end
            end
            if (k == 31 || k == 32) begin
                checks++;
                if (ready !== (k == 32)) begin
                    failures++;
                    $display("FAIL midclear_ready_edge%0d got=%b want=%b", k, ready, k == 32);
                end
            end
        end
        idle();
        #1;
        checks++;
        if (read_data1 !== 0 || read_data2 !== 0 || busy1 !== 0 || busy2 !== 0) begin
            failures++;
            $display("FAIL midclear_ignored data=%h/%h busy=%b%b want=0", read_data1, read_data2, busy1, busy2);
        end
    endtask

    initial begin
        test_reset();
        fill_pattern();
        test_clear();
        test_collision();
        test_bypass();
        test_zero();
        test_scoreboard();
        test_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
